// File: rtl/traffic_light_param.sv
// Two-road traffic light controller with programmable phase durations and latched requests.
// Optional pedestrian walk window enabled by defining TL_PED_EN.
module traffic_light_param #(
  parameter int TW              = 8,
  parameter int HWY_MIN_GREEN   = 10,
  parameter int YELLOW_TIME     = 3,
  parameter int ALL_RED_TIME    = 2,
  parameter int CNTRY_MIN_GREEN = 2,
  parameter int CNTRY_MAX_GREEN = 8,
  parameter int PED_WALK_TIME   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] phase
`ifdef TL_PED_EN
  ,
  input  logic       ped_btn,
  output logic       walk
`endif
);

  // state        | meaning
  // HWY_GREEN    | highway green, waits for min green and a request
  // HWY_YELLOW   | highway yellow
  // ALL_RED_A    | clearance before country green
  // CNTRY_GREEN  | country green, bounded by min/max
  // CNTRY_YELLOW | country yellow
  // ALL_RED_B    | clearance before highway green
  typedef enum logic [2:0] {
    HWY_GREEN    = 3'd0,
    HWY_YELLOW   = 3'd1,
    ALL_RED_A    = 3'd2,
    CNTRY_GREEN  = 3'd3,
    CNTRY_YELLOW = 3'd4,
    ALL_RED_B    = 3'd5
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam int TMAX = (1 << TW) - 1;

  generate
    if (TW < 1 || TW > 30) begin : g_bad_tw
      $error("traffic_light_param: TW out of range");
    end
    if (HWY_MIN_GREEN < 1 || HWY_MIN_GREEN > TMAX) begin : g_bad_hmg
      $error("traffic_light_param: HWY_MIN_GREEN out of range");
    end
    if (YELLOW_TIME < 1 || YELLOW_TIME > TMAX) begin : g_bad_yt
      $error("traffic_light_param: YELLOW_TIME out of range");
    end
    if (ALL_RED_TIME < 1 || ALL_RED_TIME > TMAX) begin : g_bad_art
      $error("traffic_light_param: ALL_RED_TIME out of range");
    end
    if (CNTRY_MIN_GREEN < 1 || CNTRY_MIN_GREEN > TMAX) begin : g_bad_cmin
      $error("traffic_light_param: CNTRY_MIN_GREEN out of range");
    end
    if (CNTRY_MAX_GREEN < 1 || CNTRY_MAX_GREEN > TMAX) begin : g_bad_cmax
      $error("traffic_light_param: CNTRY_MAX_GREEN out of range");
    end
    if (CNTRY_MIN_GREEN > CNTRY_MAX_GREEN) begin : g_bad_cord
      $error("traffic_light_param: CNTRY_MIN_GREEN exceeds CNTRY_MAX_GREEN");
    end
    if (PED_WALK_TIME < 1 || PED_WALK_TIME > TMAX) begin : g_bad_pw
      $error("traffic_light_param: PED_WALK_TIME out of range");
    end
  endgenerate

  // Last timer value of each phase: a D-cycle phase leaves when timer == D-1.
  localparam logic [TW-1:0] HG_LAST   = TW'(HWY_MIN_GREEN - 1);
  localparam logic [TW-1:0] Y_LAST    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_LAST   = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] CMIN_LAST = TW'(CNTRY_MIN_GREEN - 1);
  localparam logic [TW-1:0] CMAX_LAST = TW'(CNTRY_MAX_GREEN - 1);
`ifdef TL_PED_EN
  localparam logic [TW-1:0] PW_LAST   = TW'(PED_WALK_TIME - 1);
`endif

  state_t        state;
  logic [TW-1:0] timer;
  logic          req;
  logic          req_window;
  logic          any_req;
  logic          hg_go;
  logic          cg_early;
  logic          cg_go;
`ifdef TL_PED_EN
  logic          ped_req;
  logic          walk_on;
`endif

  always_comb begin
    req_window = (state == HWY_GREEN) || (state == HWY_YELLOW) || (state == ALL_RED_B);
    any_req    = req | sensor;
`ifdef TL_PED_EN
    any_req    = any_req | ped_req | ped_btn;
`endif
    hg_go      = (timer >= HG_LAST) && any_req;
    cg_early   = !sensor && (timer >= CMIN_LAST);
`ifdef TL_PED_EN
    // An open walk window holds the country green until the walk time is served.
    if (walk_on && (timer < PW_LAST)) cg_early = 1'b0;
`endif
    cg_go      = (timer >= CMAX_LAST) || cg_early;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= HWY_GREEN;
      timer   <= '0;
      req     <= 1'b0;
`ifdef TL_PED_EN
      ped_req <= 1'b0;
      walk_on <= 1'b0;
`endif
    end else begin
      timer <= (timer == '1) ? timer : timer + 1'b1;
      if (req_window && sensor) req <= 1'b1;
`ifdef TL_PED_EN
      if (req_window && ped_btn) ped_req <= 1'b1;
`endif
      case (state)
        HWY_GREEN: begin
          if (hg_go) begin
            state <= HWY_YELLOW;
            timer <= '0;
          end
        end
        HWY_YELLOW: begin
          if (timer >= Y_LAST) begin
            state <= ALL_RED_A;
            timer <= '0;
          end
        end
        ALL_RED_A: begin
          if (timer >= AR_LAST) begin
            state   <= CNTRY_GREEN;
            timer   <= '0;
            req     <= 1'b0;
`ifdef TL_PED_EN
            ped_req <= 1'b0;
            walk_on <= ped_req;
`endif
          end
        end
        CNTRY_GREEN: begin
`ifdef TL_PED_EN
          if (walk_on && (timer >= PW_LAST)) walk_on <= 1'b0;
`endif
          if (cg_go) begin
            state   <= CNTRY_YELLOW;
            timer   <= '0;
`ifdef TL_PED_EN
            walk_on <= 1'b0;
`endif
          end
        end
        CNTRY_YELLOW: begin
          if (timer >= Y_LAST) begin
            state <= ALL_RED_B;
            timer <= '0;
          end
        end
        ALL_RED_B: begin
          if (timer >= AR_LAST) begin
            state <= HWY_GREEN;
            timer <= '0;
          end
        end
        default: begin
          state <= HWY_GREEN;
          timer <= '0;
        end
      endcase
    end
  end

  always_comb begin
    hwy   = RED;
    cntry = RED;
    phase = state;
    case (state)
      HWY_GREEN:    hwy   = GREEN;
      HWY_YELLOW:   hwy   = YELLOW;
      CNTRY_GREEN:  cntry = GREEN;
      CNTRY_YELLOW: cntry = YELLOW;
      default: ;
    endcase
  end

`ifdef TL_PED_EN
  assign walk = walk_on;
`endif

endmodule

// File: tb/tb_traffic_light_param.sv
// Scoreboard bench for traffic_light_param at default parameters.
// Each queue entry holds the inputs for one edge and the lamp/phase expected after it.
module tb_traffic_light_param;

  logic       clk;
  logic       reset;
  logic       sensor;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] phase;
`ifdef TL_PED_EN
  logic       ped_btn;
  logic       walk;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       sens;
    logic       ped;
    logic [1:0] h;
    logic [1:0] c;
    logic [2:0] p;
    logic       w;
  } exp_t;

  exp_t sb[$];

  traffic_light_param dut (
    .clk    (clk),
    .reset  (reset),
    .sensor (sensor),
    .hwy    (hwy),
    .cntry  (cntry),
    .phase  (phase)
`ifdef TL_PED_EN
    ,
    .ped_btn(ped_btn),
    .walk   (walk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic push(input int n, input logic r, input logic s, input logic pd,
                      input logic [2:0] p, input logic w);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.rst  = r;
      e.sens = s;
      e.ped  = pd;
      e.p    = p;
      e.h    = (p == 3'd0) ? 2'b10 : (p == 3'd1) ? 2'b01 : 2'b00;
      e.c    = (p == 3'd3) ? 2'b10 : (p == 3'd4) ? 2'b01 : 2'b00;
      e.w    = w;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input exp_t e);
    reset  = e.rst;
    sensor = e.sens;
`ifdef TL_PED_EN
    ped_btn = e.ped;
`endif
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    sensor = 1'b0;
`ifdef TL_PED_EN
    ped_btn = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   n = 0;
    reset  = 1'b0;
    sensor = 1'b1;
`ifdef TL_PED_EN
    ped_btn = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({hwy, cntry, phase} !== {2'b10, 2'b00, 3'd0}) begin
        failures++;
        $display("FAIL reset_hold edge%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=10 cntry=00 phase=0",
                 i, hwy, cntry, phase);
      end
    end
    push(50, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      drive(e);
      @(posedge clk);
      #1;
      n++;
      checks++;
      if ({hwy, cntry, phase} !== {e.h, e.c, e.p}) begin
        failures++;
        $display("FAIL reset_idle step%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=%b cntry=%b phase=%0d",
                 n, hwy, cntry, phase, e.h, e.c, e.p);
      end
`ifdef TL_PED_EN
      checks++;
      if (walk !== e.w) begin
        failures++;
        $display("FAIL reset_idle_walk step%0d: got walk=%b, expected walk=%b", n, walk, e.w);
      end
`endif
    end
  endtask

  task automatic test_single_pulse();
    exp_t e;
    int   n = 0;
    apply_reset();
    push(2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    push(1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    push(6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    push(3, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    push(3, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
    push(10, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      drive(e);
      @(posedge clk);
      #1;
      n++;
      checks++;
      if ({hwy, cntry, phase} !== {e.h, e.c, e.p}) begin
        failures++;
        $display("FAIL single_pulse step%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=%b cntry=%b phase=%0d",
                 n, hwy, cntry, phase, e.h, e.c, e.p);
      end
`ifdef TL_PED_EN
      checks++;
      if (walk !== e.w) begin
        failures++;
        $display("FAIL single_pulse_walk step%0d: got walk=%b, expected walk=%b", n, walk, e.w);
      end
`endif
    end
  endtask

  task automatic test_sensor_held();
    exp_t e;
    int   n = 0;
    apply_reset();
    push(9, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    push(3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
    push(8, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
    push(3, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0);
    push(2, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0);
    push(10, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    push(3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
    push(1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      drive(e);
      @(posedge clk);
      #1;
      n++;
      checks++;
      if ({hwy, cntry, phase} !== {e.h, e.c, e.p}) begin
        failures++;
        $display("FAIL sensor_held step%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=%b cntry=%b phase=%0d",
                 n, hwy, cntry, phase, e.h, e.c, e.p);
      end
`ifdef TL_PED_EN
      checks++;
      if (walk !== e.w) begin
        failures++;
        $display("FAIL sensor_held_walk step%0d: got walk=%b, expected walk=%b", n, walk, e.w);
      end
`endif
    end
  endtask

  task automatic test_late_sensor();
    exp_t e;
    int   n = 0;
    apply_reset();
    push(19, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    push(1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0);
    push(3, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
    push(5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      drive(e);
      @(posedge clk);
      #1;
      n++;
      checks++;
      if ({hwy, cntry, phase} !== {e.h, e.c, e.p}) begin
        failures++;
        $display("FAIL late_sensor step%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=%b cntry=%b phase=%0d",
                 n, hwy, cntry, phase, e.h, e.c, e.p);
      end
`ifdef TL_PED_EN
      checks++;
      if (walk !== e.w) begin
        failures++;
        $display("FAIL late_sensor_walk step%0d: got walk=%b, expected walk=%b", n, walk, e.w);
      end
`endif
    end
  endtask

  task automatic test_reset_midphase();
    exp_t e;
    int   n = 0;
    apply_reset();
    push(9, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    push(3, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0);
    push(3, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
    push(1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    push(20, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      drive(e);
      @(posedge clk);
      #1;
      n++;
      checks++;
      if ({hwy, cntry, phase} !== {e.h, e.c, e.p}) begin
        failures++;
        $display("FAIL reset_midphase step%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=%b cntry=%b phase=%0d",
                 n, hwy, cntry, phase, e.h, e.c, e.p);
      end
`ifdef TL_PED_EN
      checks++;
      if (walk !== e.w) begin
        failures++;
        $display("FAIL reset_midphase_walk step%0d: got walk=%b, expected walk=%b", n, walk, e.w);
      end
`endif
    end
  endtask

`ifdef TL_PED_EN
  task automatic test_ped_walk();
    exp_t e;
    int   n = 0;
    apply_reset();
    push(2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    push(1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
    push(6, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    push(3, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    push(6, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1);
    push(3, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
    push(2, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
    push(5, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      drive(e);
      @(posedge clk);
      #1;
      n++;
      checks++;
      if ({hwy, cntry, phase} !== {e.h, e.c, e.p}) begin
        failures++;
        $display("FAIL ped_walk step%0d: got hwy=%b cntry=%b phase=%0d, expected hwy=%b cntry=%b phase=%0d",
                 n, hwy, cntry, phase, e.h, e.c, e.p);
      end
      checks++;
      if (walk !== e.w) begin
        failures++;
        $display("FAIL ped_walk_walk step%0d: got walk=%b, expected walk=%b", n, walk, e.w);
      end
    end
  endtask
`endif

  initial begin
    reset  = 1'b0;
    sensor = 1'b0;
`ifdef TL_PED_EN
    ped_btn = 1'b0;
`endif
    #1;
    test_reset();
    test_single_pulse();
    test_sensor_held();
    test_late_sensor();
    test_reset_midphase();
`ifdef TL_PED_EN
    test_ped_walk();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
